// File: rtl/mem_line_pkg.sv
// mem_line_pkg: shared constants, beat/line types and FSM states for the line controller
package mem_line_pkg;
   localparam int LINE_WORDS = 16;
   localparam int OFF_W = 4;
   localparam int LINE_ADDR_W = 26;
   typedef logic [OFF_W-1:0] beat_t;
   typedef logic [LINE_ADDR_W-1:0] line_t;
   typedef enum logic [2:0] {IDLE, WB_WAIT, WB_BEAT, FILL_WAIT, FILL_BEAT} state_t;
endpackage

// File: rtl/mem_line_store.sv
// mem_line_store: single-port backing word array, synchronous write, registered read, array never reset
module mem_line_store #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);
   logic [31:0] mem [2**ADDR_W];
   // write when enabled; the read register always follows the addressed word
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: line refill / write-back controller over the backing store; optional stats via MEM_LINE_CTRL_STATS_EN
module mem_line_ctrl
   import mem_line_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int LATENCY = 20
) (
   input  logic        clock_me,
   input  logic        reset_0,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wb,
   input  line_t       req_fill_line,
   input  line_t       req_wb_line,
   output beat_t       wb_idx,
   input  logic [31:0] wb_data,
   output logic        wb_beat,
   output logic        fill_valid,
   output beat_t       fill_idx,
   output logic [31:0] fill_data,
   output logic        done,
   output logic        busy
`ifdef MEM_LINE_CTRL_STATS_EN
   ,
   output logic [31:0] stat_fills,
   output logic [31:0] stat_wbs,
   output logic [31:0] stat_busy_cycles
`endif
);
   localparam int LW = ADDR_W - OFF_W;
   localparam logic [7:0] LAT = 8'(LATENCY);
   localparam beat_t LAST = beat_t'(LINE_WORDS - 1);
   state_t state;
   beat_t beat;
   logic [7:0] cnt;
   logic [LW-1:0] fill_line, wb_line;
   logic [31:0] rdata;
   logic [ADDR_W-1:0] addr;
   logic unused_hi;
   assign unused_hi = ^{req_fill_line[LINE_ADDR_W-1:LW], req_wb_line[LINE_ADDR_W-1:LW]};
   assign wb_idx = beat;
   assign fill_idx = beat;
   assign fill_data = fill_valid ? rdata : '0;
   // write-back beats own the port; otherwise prefetch the next fill word one cycle ahead
   assign addr = state == WB_BEAT ? {wb_line, beat}
               : {fill_line, state == FILL_BEAT ? beat + beat_t'(1) : beat_t'(0)};
   mem_line_store #(.ADDR_W(ADDR_W)) u_store (
      .clk(clock_me),
      .we(state == WB_BEAT),
      .addr(addr),
      .wdata(wb_data),
      .rdata(rdata)
   );
   // transaction sequencer: wait and beat phases with registered handshake outputs
   always_ff @(posedge clock_me) begin
      if (reset_0) begin
         state <= IDLE;
         cnt <= '0;
         beat <= '0;
         req_ready <= 1'b1;
         busy <= 1'b0;
         wb_beat <= 1'b0;
         fill_valid <= 1'b0;
         done <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               state <= req_wb ? WB_WAIT : FILL_WAIT;
               fill_line <= req_fill_line[LW-1:0];
               wb_line <= req_wb_line[LW-1:0];
               cnt <= LAT;
               req_ready <= 1'b0;
               busy <= 1'b1;
            end
            WB_WAIT, FILL_WAIT: if (cnt == 8'd1) begin
               state <= state == WB_WAIT ? WB_BEAT : FILL_BEAT;
               wb_beat <= state == WB_WAIT;
               fill_valid <= state == FILL_WAIT;
               beat <= '0;
            end else cnt <= cnt - 8'd1;
            WB_BEAT: begin
               beat <= beat + beat_t'(1);
               if (beat == LAST) begin
                  state <= FILL_WAIT;
                  wb_beat <= 1'b0;
                  cnt <= LAT;
               end
            end
            FILL_BEAT: begin
               beat <= beat + beat_t'(1);
               done <= beat == LAST - beat_t'(1);
               if (beat == LAST) begin
                  state <= IDLE;
                  fill_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef MEM_LINE_CTRL_STATS_EN
   // saturating activity counters
   always_ff @(posedge clock_me) begin
      if (reset_0) begin
         stat_fills <= '0;
         stat_wbs <= '0;
         stat_busy_cycles <= '0;
      end else begin
         if (done && ~&stat_fills) stat_fills <= stat_fills + 32'd1;
         if (state == WB_BEAT && beat == LAST && ~&stat_wbs) stat_wbs <= stat_wbs + 32'd1;
         if (busy && ~&stat_busy_cycles) stat_busy_cycles <= stat_busy_cycles + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_mem_line_ctrl.sv
// tb_mem_line_ctrl: randomized and directed line transactions checked against a timeline model of the controller
module tb_mem_line_ctrl;
   localparam int L = 20;
   logic clock_me = 1'b0;
   logic reset_0, req_valid, req_ready, req_wb, wb_beat, fill_valid, done, busy;
   logic [25:0] req_fill_line, req_wb_line;
   logic [3:0] wb_idx, fill_idx;
   logic [31:0] wb_data, fill_data;
   int n_vec = 0, n_bad = 0;
   logic [31:0] wb_tab [16];
   logic [31:0] got [16];
   int r_first, r_wait;
   bit r_done;
   // model state: transaction timeline measured in cycles since acceptance
   logic [31:0] m_mem [1024];
   bit m_known [1024];
   bit m_act = 0, m_wb = 0, started = 0;
   int m_t = 0;
   logic [25:0] m_wbl, m_fl;
   logic [31:0] m_tab [16];

   always #5 clock_me = ~clock_me;

   mem_line_ctrl #(.ADDR_W(10), .LATENCY(L)) u_dut (
      .clock_me(clock_me), .reset_0(reset_0), .req_valid(req_valid), .req_ready(req_ready),
      .req_wb(req_wb), .req_fill_line(req_fill_line), .req_wb_line(req_wb_line),
      .wb_idx(wb_idx), .wb_data(wb_data), .wb_beat(wb_beat), .fill_valid(fill_valid),
      .fill_idx(fill_idx), .fill_data(fill_data), .done(done), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // model advance: store writes happen for the beat in progress, even on a reset edge
   always @(posedge clock_me) begin
      int w, a;
      started = 1;
      w = m_t - L - 1;
      if (m_act && m_wb && w >= 0 && w < 16) begin
         a = (int'(m_wbl) % 64) * 16 + w;
         m_mem[a] = m_tab[w];
         m_known[a] = 1;
      end
      if (reset_0) m_act = 0;
      else if (m_act) begin
         if (m_t == L + 16 + (m_wb ? L + 16 : 0)) m_act = 0;
         else m_t++;
      end else if (req_valid) begin
         m_act = 1;
         m_t = 1;
         m_wb = req_wb;
         m_wbl = req_wb_line;
         m_fl = req_fill_line;
         for (int i = 0; i < 16; i++) m_tab[i] = wb_tab[i];
      end
   end

   // compare process: every cycle, away from the active edge
   always @(negedge clock_me) begin
      int off, w, f, a;
      bit e_wb, e_fv;
      if (started) begin
         off = m_wb ? L + 16 : 0;
         w = m_t - L - 1;
         f = m_t - off - L - 1;
         e_wb = m_act && m_wb && w >= 0 && w < 16;
         e_fv = m_act && f >= 0 && f < 16;
         chk("flags{ready,busy,wb_beat,fill_valid,done}", {27'd0, req_ready, busy, wb_beat, fill_valid, done},
             {27'd0, !m_act, m_act, e_wb, e_fv, e_fv && f == 15});
         if (e_wb) chk("wb_idx", {28'd0, wb_idx}, w);
         if (e_fv) begin
            chk("fill_idx", {28'd0, fill_idx}, f);
            a = (int'(m_fl) % 64) * 16 + f;
            if (m_known[a]) chk("fill_data", fill_data, m_mem[a]);
         end
      end
   end

   task automatic step();
      @(negedge clock_me);
      wb_data = wb_tab[wb_idx];
   endtask

   task automatic run_txn(input bit wb, input logic [25:0] wbl, input logic [25:0] fl, input logic [31:0] base,
                          input bit tog, input bit keep, input int rst_at);
      r_wait = 0;
      r_first = -1;
      r_done = 0;
      for (int i = 0; i < 16; i++) got[i] = 32'hxxxxxxxx;
      while (!req_ready && r_wait < 300) begin
         step();
         r_wait++;
      end
      if (!req_ready) chk("ready_timeout", {31'd0, req_ready}, 1);
      for (int i = 0; i < 16; i++) wb_tab[i] = base + i;
      req_valid = 1;
      req_wb = wb;
      req_wb_line = wbl;
      req_fill_line = fl;
      wb_data = wb_tab[wb_idx];
      for (int n = 1; n <= 300; n++) begin
         step();
         if (!keep) begin
            req_valid = tog ? 1'($urandom) : 1'b0;
            if (tog) begin
               req_wb = 1'($urandom);
               req_wb_line = 26'($urandom);
               req_fill_line = 26'($urandom);
            end
         end
         if (rst_at >= 0 && wb_beat && wb_idx == 4'(rst_at)) begin
            reset_0 = 1;
            req_valid = 0;
            step();
            reset_0 = 0;
            return;
         end
         if (fill_valid) begin
            if (r_first < 0) r_first = n;
            got[fill_idx] = fill_data;
         end
         if (done) begin
            r_done = 1;
            if (keep) begin
               req_wb = wb;
               req_wb_line = wbl;
               req_fill_line = fl;
            end else req_valid = 0;
            return;
         end
      end
      chk("done_timeout", {31'd0, done}, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_0 = 1; req_valid = 0; req_wb = 0; req_fill_line = '0; req_wb_line = '0; wb_data = '0;
      for (int i = 0; i < 16; i++) wb_tab[i] = '0;
      repeat (3) step();
      reset_0 = 0;
      // preload lines 4, 3 and 0x40 (wraps to line 0) through write-backs
      run_txn(1, 26'd4, 26'd9, 32'h1000, 0, 0, -1);
      run_txn(1, 26'd3, 26'd9, 32'h3300, 0, 0, -1);
      run_txn(1, 26'h40, 26'd9, 32'h0C00, 0, 0, -1);
      // fill-only: beats start LATENCY+1 cycles after the request cycle
      run_txn(0, 26'd0, 26'd4, 32'h0, 0, 0, -1);
      chk("fill4_first", r_first, L + 1);
      chk("fill4_d0", got[0], 32'h1000);
      chk("fill4_d15", got[15], 32'h100F);
      chk("fill4_done", {31'd0, r_done}, 1);
      // write-back + fill adds LATENCY+16
      run_txn(1, 26'd2, 26'd5, 32'hA0, 0, 0, -1);
      chk("wbfill_first", r_first, 2 * L + 17);
      run_txn(0, 26'd0, 26'd2, 32'h0, 0, 0, -1);
      chk("line2_d0", got[0], 32'hA0);
      chk("line2_d15", got[15], 32'hAF);
      // same line for write-back and fill
      run_txn(1, 26'd7, 26'd7, 32'hDEAD0000, 0, 0, -1);
      chk("same_d0", got[0], 32'hDEAD0000);
      chk("same_d15", got[15], 32'hDEAD000F);
      // reset during write-back beat 5
      run_txn(1, 26'd3, 26'd3, 32'h5500, 0, 0, 5);
      chk("rst_ready", {31'd0, req_ready}, 1);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_nodone", {31'd0, r_done}, 0);
      run_txn(0, 26'd0, 26'd3, 32'h0, 0, 0, -1);
      chk("rst_w5", got[5], 32'h5505);
      chk("rst_w6", got[6], 32'h3306);
      // held request: second accepted only after done; line 0x40 reads line 0
      run_txn(0, 26'd0, 26'h40, 32'h0, 0, 1, -1);
      run_txn(0, 26'd0, 26'h40, 32'h0, 0, 0, -1);
      chk("b2b_wait", r_wait, 1);
      chk("wrap_d0", got[0], 32'h0C00);
      chk("wrap_d15", got[15], 32'h0C0F);
      // inputs toggling while busy are ignored
      run_txn(1, 26'd6, 26'd1, 32'h6600, 1, 0, -1);
      run_txn(0, 26'd0, 26'd6, 32'h0, 0, 0, -1);
      chk("tog_d9", got[9], 32'h6609);
      // randomized traffic
      for (int k = 0; k < 25; k++) begin
         bit wb;
         wb = 1'($urandom);
         run_txn(wb, {20'($urandom), 6'($urandom_range(0, 7))}, {20'($urandom), 6'($urandom_range(0, 7))},
                 $urandom, ($urandom % 3) == 0, 0, (wb && ($urandom % 6) == 0) ? int'($urandom % 16) : -1);
         repeat ($urandom % 3) step();
      end
      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
